w0rm_store_narrow: RTL and testbench

Store-path narrowing unit for the W0RM core: the write-side counterpart of the ALU sign/zero-extend stage. It takes a 32-bit register value, an access size (byte/half/word) and a byte address, truncates the value to the access size, and places it on the correct byte lanes of a word-aligned memory write port with byte enables. It sits between the execute stage and the data-memory write port. Misaligned accesses that straddle a word boundary are split into two bus beats.

---
 rtl/w0rm_store_narrow_if.sv | 29 ++
 rtl/w0rm_store_narrow.sv | 145 ++++++++++++++
 tb/tb_w0rm_store_narrow.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/w0rm_store_narrow_if.sv
// Store request and memory write-port bundle for w0rm_store_narrow.
// The slave modport is the unit's view; master is the driving side.
interface w0rm_store_narrow_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  data_valid;
    logic                  in_ready;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [3:0]            mem_byte_en;
    logic                  done;
    logic                  fault;

    modport slave (
        input  data_valid, size, addr, data, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_data, mem_byte_en, done, fault
    );

    modport master (
        output data_valid, size, addr, data, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_data, mem_byte_en, done, fault
    );
endinterface

// File: rtl/w0rm_store_narrow.sv
// Store narrowing: truncates a register value to byte/half/word and lane-aligns it onto
// a word-wide write port. Define W0RM_STORE_SPLIT_EN to split word-straddling stores into two beats.
module w0rm_store_narrow #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    w0rm_store_narrow_if.slave  bus
);
    // state | meaning
    // IDLE  | ready for a request
    // BEAT1 | first (or only) write beat on the bus
    // BEAT2 | second beat of a word-straddling store
    // DONE  | one-cycle completion pulse
    // FAULT | one-cycle rejection pulse, no beat issued
    typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, DONE, FAULT} state_t;

    state_t                state;
    logic                  in_ready_q;
    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [3:0]            mem_byte_en_q;
    logic                  done_q;
    logic                  fault_q;

    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] masked;
    logic [DATA_WIDTH-1:0] lo_data;
    logic [3:0]            en4;
    logic [7:0]            en8;
    logic                  bad;
`ifdef W0RM_STORE_SPLIT_EN
    logic [DATA_WIDTH-1:0] hi_data;
    logic [DATA_WIDTH-1:0] hi_data_q;
    logic [3:0]            hi_en_q;
`endif

    always_comb begin
        mask = '0;
        en4  = 4'b0000;
        case (bus.size)
            2'b00:   begin mask = DATA_WIDTH'(32'h0000_00FF); en4 = 4'b0001; end
            2'b01:   begin mask = DATA_WIDTH'(32'h0000_FFFF); en4 = 4'b0011; end
            2'b10:   begin mask = '1;                         en4 = 4'b1111; end
            default: begin mask = '0;                         en4 = 4'b0000; end
        endcase
        masked = bus.data & mask;
        en8    = {4'b0000, en4} << bus.addr[1:0];
`ifdef W0RM_STORE_SPLIT_EN
        {hi_data, lo_data} = {{DATA_WIDTH{1'b0}}, masked} << {bus.addr[1:0], 3'b000};
        bad = (bus.size == 2'b11);
`else
        // Only the in-word part is needed; anything spilling past the word faults.
        lo_data = masked << {bus.addr[1:0], 3'b000};
        bad = (bus.size == 2'b11) || (en8[7:4] != 4'b0000);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            in_ready_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_byte_en_q <= 4'b0000;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
`ifdef W0RM_STORE_SPLIT_EN
            hi_data_q     <= '0;
            hi_en_q       <= 4'b0000;
`endif
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (bad) begin
                            state   <= FAULT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state         <= BEAT1;
                            mem_valid_q   <= 1'b1;
                            mem_addr_q    <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_data_q    <= lo_data;
                            mem_byte_en_q <= en8[3:0];
`ifdef W0RM_STORE_SPLIT_EN
                            hi_data_q     <= hi_data;
                            hi_en_q       <= en8[7:4];
`endif
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                BEAT1: begin
                    if (bus.mem_ready) begin
`ifdef W0RM_STORE_SPLIT_EN
                        if (hi_en_q != 4'b0000) begin
                            state         <= BEAT2;
                            mem_addr_q    <= mem_addr_q + ADDR_WIDTH'(4);
                            mem_data_q    <= hi_data_q;
                            mem_byte_en_q <= hi_en_q;
                        end else begin
                            state       <= DONE;
                            mem_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
`else
                        state       <= DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
`endif
                    end
                end
`ifdef W0RM_STORE_SPLIT_EN
                BEAT2: begin
                    if (bus.mem_ready) begin
                        state       <= DONE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_byte_en = mem_byte_en_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_w0rm_store_narrow.sv
// Directed bench for w0rm_store_narrow; expectations follow W0RM_STORE_SPLIT_EN
// (split stores when defined, faults on straddling stores otherwise).
module tb_w0rm_store_narrow;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    w0rm_store_narrow_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    w0rm_store_narrow #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns in the cycle after acceptance.
    task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        check("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.data_valid = 1'b1;
        bus.size = sz;
        bus.addr = a;
        bus.data = d;
        tick();
        bus.data_valid = 1'b0;
        bus.size = 2'b00;
        bus.addr = 32'h0;
        bus.data = 32'h0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        check({tag, "_valid"}, {31'd0, bus.mem_valid}, 32'd1);
        check({tag, "_addr"}, bus.mem_addr, a);
        check({tag, "_data"}, bus.mem_data, d);
        check({tag, "_en"}, {28'd0, bus.mem_byte_en}, {28'd0, en});
        check({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic finish_ok(input string tag);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_fault"}, {31'd0, bus.fault}, 32'd0);
        check({tag, "_valid_off"}, {31'd0, bus.mem_valid}, 32'd0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic finish_fault(input string tag);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_fault"}, {31'd0, bus.fault}, 32'd1);
        check({tag, "_no_valid"}, {31'd0, bus.mem_valid}, 32'd0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_no_valid2"}, {31'd0, bus.mem_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.mem_valid}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_fault"}, {31'd0, bus.fault}, 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_data"}, bus.mem_data, 32'h0);
        check({tag, "_en"}, {28'd0, bus.mem_byte_en}, 32'd0);
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.size = 2'b00;
        bus.addr = 32'h0;
        bus.data = 32'h0;
        bus.mem_ready = 1'b1;

        tick();
        tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();
        check("rst_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // byte at off 2
        send(2'b00, 32'h0000_1002, 32'hDEAD_BEEF);
        beat("byte2", 32'h0000_1000, 32'h00EF_0000, 4'b0100);
        tick();
        finish_ok("byte2");

        // byte at off 3
        send(2'b00, 32'h0000_0007, 32'h1234_56A5);
        beat("byte3", 32'h0000_0004, 32'hA500_0000, 4'b1000);
        tick();
        finish_ok("byte3");

        // half at off 2 stays in-word in both builds
        send(2'b01, 32'h0000_0102, 32'hCAFE_BABE);
        beat("half2", 32'h0000_0100, 32'hBABE_0000, 4'b1100);
        tick();
        finish_ok("half2");

        // half at off 3
        send(2'b01, 32'h0000_0003, 32'h1234_5678);
`ifdef W0RM_STORE_SPLIT_EN
        beat("half3_b1", 32'h0000_0000, 32'h7800_0000, 4'b1000);
        tick();
        beat("half3_b2", 32'h0000_0004, 32'h0000_0056, 4'b0001);
        tick();
        finish_ok("half3");
`else
        finish_fault("half3");
`endif

        // word wrapping the address space
        send(2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD);
`ifdef W0RM_STORE_SPLIT_EN
        beat("wrap_b1", 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100);
        tick();
        beat("wrap_b2", 32'h0000_0000, 32'h0000_AABB, 4'b0011);
        tick();
        finish_ok("wrap");
`else
        finish_fault("wrap");
`endif

        // word at off 1
        send(2'b10, 32'h0000_0001, 32'h1234_5678);
`ifdef W0RM_STORE_SPLIT_EN
        beat("word1_b1", 32'h0000_0000, 32'h3456_7800, 4'b1110);
        tick();
        beat("word1_b2", 32'h0000_0004, 32'h0000_0012, 4'b0001);
        tick();
        finish_ok("word1");
`else
        finish_fault("word1");
`endif

        // invalid size
        send(2'b11, 32'h0000_0000, 32'hFFFF_FFFF);
        finish_fault("size11");

        // aligned word with a 3-cycle stall
        bus.mem_ready = 1'b0;
        send(2'b10, 32'h0000_2000, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            beat("stall", 32'h0000_2000, 32'h1122_3344, 4'b1111);
            if (i < 2) tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        finish_ok("stall");

        // reset in the middle of a transaction
`ifdef W0RM_STORE_SPLIT_EN
        send(2'b10, 32'h0000_0011, 32'h1234_5678);
        tick();
        beat("abort_b2", 32'h0000_0014, 32'h0000_0012, 4'b0001);
`else
        bus.mem_ready = 1'b0;
        send(2'b10, 32'h0000_0010, 32'h1234_5678);
        beat("abort_b1", 32'h0000_0010, 32'h1234_5678, 4'b1111);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        check_reset_outputs("abort_hold");
        reset_n = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        check("abort_no_valid", {31'd0, bus.mem_valid}, 32'd0);

        // unit still works after the abort
        send(2'b00, 32'h0000_0001, 32'h0000_0042);
        beat("post", 32'h0000_0000, 32'h0000_4200, 4'b0010);
        tick();
        finish_ok("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
